// File: rtl/ps2kbd_pkg.sv
// ps2kbd_pkg: shared FSM states, register map, status bit positions and control masks (PS2KBD_PARITY_CHECK_EN selects parity checking)
package ps2kbd_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;
  localparam int ST_NE   = 7;
  localparam int ST_FULL = 6;
  localparam int ST_OVF  = 5;
  localparam int ST_PERR = 4;
  localparam int ST_FERR = 3;
  localparam logic [7:0] CTRL_FLUSH   = 8'h01;
  localparam logic [7:0] CTRL_CLR_ERR = 8'h02;
  function automatic logic [7:0] pack_status(input logic ne, input logic full, input logic ovf,
                                             input logic perr, input logic ferr, input logic [2:0] cnt);
    logic [7:0] s;
    s = {5'b0, cnt};
    s[ST_NE] = ne;
    s[ST_FULL] = full;
    s[ST_OVF] = ovf;
    s[ST_PERR] = perr;
    s[ST_FERR] = ferr;
    return s;
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 line synchronisers, falling-edge detect, frame FSM and inactivity timeout (PS2KBD_PARITY_CHECK_EN enables odd-parity check)
module ps2_rx
  import ps2kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       perr,
  output logic       frameerr
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic clk_prev_q, clk_prev_d;
  rx_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic fall, sdat, parity_ok;
`ifdef PS2KBD_PARITY_CHECK_EN
  logic par_q, par_d;
  assign parity_ok = ^{shift_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif
  assign fall = clk_prev_q & ~clk_sync_q[1];
  assign sdat = dat_sync_q[1];
  assign byte_valid = valid_q;
  assign rx_byte = shift_q;
  assign perr = perr_q;
  assign frameerr = ferr_q;
  // shift the raw lines through the synchronisers and keep the previous synchronised clock
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    clk_prev_d = clk_sync_q[1];
  end
  // frame FSM next state: bits are taken on PS/2 clock falling edges, stalls abort the frame
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    tmo_d = '0;
    valid_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
`ifdef PS2KBD_PARITY_CHECK_EN
    par_d = par_q;
`endif
    if (state_q != RX_IDLE && !fall) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = RX_IDLE;
        tmo_d = '0;
      end
    end
    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          state_d = sdat ? RX_IDLE : RX_DATA;
          bit_cnt_d = 3'd0;
        end
        RX_DATA: begin
          shift_d = {sdat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d = (bit_cnt_q == 3'd7) ? RX_PARITY : RX_DATA;
        end
        RX_PARITY: begin
`ifdef PS2KBD_PARITY_CHECK_EN
          par_d = sdat;
`endif
          state_d = RX_STOP;
        end
        default: begin
          state_d = RX_IDLE;
          valid_d = sdat & parity_ok;
          perr_d = sdat & ~parity_ok;
          ferr_d = ~sdat;
        end
      endcase
    end
  end
  // receiver registers; synchronisers reset to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q <= '0;
      tmo_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      tmo_q <= tmo_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  end
`ifdef PS2KBD_PARITY_CHECK_EN
  // captured parity bit for the odd-parity check at the stop bit
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else par_q <= par_d;
  end
`endif
endmodule

// File: rtl/ps2kbd.sv
// ps2kbd: PS/2 keyboard receiver with byte FIFO, sticky error flags and CPU register interface (PS2KBD_PARITY_CHECK_EN enables parity errors)
module ps2kbd
  import ps2kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] dbr,
  input  logic [7:0] dbw,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       irq_n
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic rx_valid, rx_perr, rx_ferr;
  logic [7:0] rx_byte;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [7:0] dbr_q, dbr_d;
  logic empty, full, pop_req, do_pop, do_push, flush, clr;
  logic [2:0] cnt_sat;
  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(rx_valid),
    .rx_byte   (rx_byte),
    .perr      (rx_perr),
    .frameerr  (rx_ferr)
  );
  assign empty = (cnt_q == '0);
  assign full = (cnt_q == CW'(FIFO_DEPTH));
  assign pop_req = we && addr == REG_STATUS;
  assign flush = we && addr == REG_CTRL && |(dbw & CTRL_FLUSH);
  assign clr = we && addr == REG_CTRL && |(dbw & CTRL_CLR_ERR);
  assign do_pop = pop_req & ~empty;
  assign do_push = rx_valid & (~full | do_pop);
  assign cnt_sat = (32'(cnt_q) > 7) ? 3'd7 : 3'(cnt_q);
  assign dbr = dbr_q;
  assign irq_n = empty;
  // FIFO pointer/count update, sticky flags and the registered bus read mux
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) mem_d[wr_q] = rx_byte;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
    end
    ovf_d = (ovf_q & ~clr) | (rx_valid & full & ~pop_req);
    perr_d = (perr_q & ~clr) | rx_perr;
    ferr_d = (ferr_q & ~clr) | rx_ferr;
    dbr_d = (addr == REG_DATA) ? (empty ? 8'h00 : mem_q[rd_q]) :
            (addr == REG_STATUS) ? pack_status(~empty, full, ovf_q, perr_q, ferr_q, cnt_sat) : 8'hFF;
  end
  // FIFO storage needs no reset; only pointers and count define its contents
  always_ff @(posedge clk) mem_q <= mem_d;
  // control state and bus read register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      dbr_q <= 8'h00;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      dbr_q <= dbr_d;
    end
  end
endmodule

// File: tb/tb_ps2kbd.sv
// tb_ps2kbd: directed self-checking bench for ps2kbd (expectations follow PS2KBD_PARITY_CHECK_EN)
module tb_ps2kbd;
  logic clk = 1'b0, rst = 1'b1, we = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] dbw = 8'h00;
  logic [7:0] dbr;
  logic irq_n;
  int checks = 0, errors = 0;
  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] dbw;
    logic [7:0] exp_dbr;
    logic       exp_irq_n;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  ps2kbd dut (
    .clk     (clk),
    .rst     (rst),
    .dbr     (dbr),
    .dbw     (dbw),
    .addr    (addr),
    .we      (we),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .irq_n   (irq_n)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    tick(5);
    ps2_clk = 1'b0;
    tick(10);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_head(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par_ok ? ~^b : ^b);
    send_bit(stop);
    ps2_data = 1'b1;
    tick(5);
  endtask

  // sends a good frame and issues a bus write in the very cycle the receiver presents the byte
  task automatic send_frame_act(input logic [7:0] b, input logic [1:0] a, input logic [7:0] d);
    logic found;
    found = 1'b0;
    send_head(b);
    ps2_data = 1'b1;
    tick(5);
    ps2_clk = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (dut.rx_valid) found = 1'b1;
    end
    chk("rx_valid_seen", {7'b0, found}, 8'h01);
    if (found) begin
      addr = a;
      dbw = d;
      we = 1'b1;
      @(posedge clk);
      #1 we = 1'b0;
    end
    tick(10);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    addr = a;
    tick(1);
    v = dbr;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr = a;
    dbw = d;
    we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    vecs[0] = '{1'b0, 2'd1, 8'h00, 8'h81, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 8'h00, 8'h1C, 1'b0};
    vecs[2] = '{1'b0, 2'd2, 8'h00, 8'hFF, 1'b0};
    vecs[3] = '{1'b0, 2'd3, 8'h00, 8'hFF, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 8'h03, 8'h1C, 1'b0};
    vecs[5] = '{1'b1, 2'd3, 8'h03, 8'hFF, 1'b0};
    vecs[6] = '{1'b0, 2'd1, 8'h00, 8'h81, 1'b0};
    vecs[7] = '{1'b1, 2'd1, 8'h00, 8'h00, 1'b1};
    vecs[8] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1};
    vecs[9] = '{1'b1, 2'd1, 8'h00, 8'h00, 1'b1};

    tick(3);
    chk("reset_dbr", dbr, 8'h00);
    chk("reset_irq_n", {7'b0, irq_n}, 8'h01);
    rst = 1'b0;
    tick(2);

    send_frame(8'h1C, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      addr = vecs[i].addr;
      dbw = vecs[i].dbw;
      we = vecs[i].we;
      tick(1);
      we = 1'b0;
      tick(1);
      chk($sformatf("vec%0d_dbr", i), dbr, vecs[i].exp_dbr);
      chk($sformatf("vec%0d_irq_n", i), {7'b0, irq_n}, {7'b0, vecs[i].exp_irq_n});
    end

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b1);
    rd(2'd1, r); chk("ovf_status", r, 8'hE7);
    for (int i = 0; i < 8; i++) begin
      rd(2'd0, r); chk($sformatf("ovf_pop%0d", i), r, 8'(i + 1));
      wr(2'd1, 8'h00);
    end
    rd(2'd1, r); chk("ovf_after_drain", r, 8'h20);
    wr(2'd2, 8'h02);
    rd(2'd1, r); chk("ovf_cleared", r, 8'h00);

    send_frame(8'h66, 1'b1, 1'b0);
    rd(2'd1, r); chk("frameerr_status", r, 8'h08);
    rd(2'd0, r); chk("frameerr_no_byte", r, 8'h00);
    wr(2'd2, 8'h02);
    rd(2'd1, r); chk("frameerr_cleared", r, 8'h00);

    send_frame(8'h55, 1'b0, 1'b1);
`ifdef PS2KBD_PARITY_CHECK_EN
    rd(2'd1, r); chk("parity_status", r, 8'h10);
    rd(2'd0, r); chk("parity_head", r, 8'h00);
`else
    rd(2'd1, r); chk("parity_status", r, 8'h81);
    rd(2'd0, r); chk("parity_head", r, 8'h55);
`endif
    wr(2'd2, 8'h03);
    rd(2'd1, r); chk("parity_flush_clear", r, 8'h00);

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    tick(2100);
    send_frame(8'hF0, 1'b1, 1'b1);
    rd(2'd1, r); chk("timeout_status", r, 8'h81);
    rd(2'd0, r); chk("timeout_head", r, 8'hF0);
    wr(2'd2, 8'h01);
    rd(2'd1, r); chk("timeout_flushed", r, 8'h00);

    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b1);
    rd(2'd1, r); chk("full_status", r, 8'hC7);
    send_frame_act(8'h18, 2'd1, 8'h00);
    rd(2'd1, r); chk("push_pop_full_status", r, 8'hC7);
    for (int i = 0; i < 8; i++) begin
      rd(2'd0, r); chk($sformatf("push_pop_order%0d", i), r, 8'(8'h11 + i));
      wr(2'd1, 8'h00);
    end
    rd(2'd1, r); chk("push_pop_drained", r, 8'h00);

    send_frame(8'h44, 1'b1, 1'b1);
    send_frame(8'h77, 1'b1, 1'b0);
    rd(2'd1, r); chk("pre_flush_status", r, 8'h89);
    send_frame_act(8'h33, 2'd2, 8'h03);
    rd(2'd1, r); chk("flush_push_status", r, 8'h00);
    chk("flush_push_irq_n", {7'b0, irq_n}, 8'h01);

    send_frame(8'h5A, 1'b1, 1'b1);
    rd(2'd1, r); chk("pre_reset_status", r, 8'h81);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    tick(1);
    chk("midreset_dbr", dbr, 8'h00);
    chk("midreset_irq_n", {7'b0, irq_n}, 8'h01);
    rst = 1'b0;
    rd(2'd1, r); chk("post_reset_status", r, 8'h00);
    rd(2'd0, r); chk("post_reset_head", r, 8'h00);
    send_frame(8'h2A, 1'b1, 1'b1);
    rd(2'd1, r); chk("after_reset_status", r, 8'h81);
    rd(2'd0, r); chk("after_reset_head", r, 8'h2A);
    chk("after_reset_irq_n", {7'b0, irq_n}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
